// File: rtl/booth_seq_ctrl_if.sv
// Request/result bundle for the sequential A*A + B calculator.
// The abort wire exists only when BOOTH_SEQ_ABORT_EN is defined.
interface booth_seq_ctrl_if;
    logic               start;
    logic signed [7:0]  A;
    logic        [15:0] B;
    logic               in_car;
    logic               busy;
    logic               done;
    logic        [15:0] sum;
    logic               carry;
`ifdef BOOTH_SEQ_ABORT_EN
    logic               abort;
`endif

    modport master (
        output start, A, B, in_car,
        input  busy, done, sum, carry
`ifdef BOOTH_SEQ_ABORT_EN
        , output abort
`endif
    );

    modport slave (
        input  start, A, B, in_car,
        output busy, done, sum, carry
`ifdef BOOTH_SEQ_ABORT_EN
        , input abort
`endif
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential signed A*A + B + in_car using one radix-4 Booth digit per cycle.
// Optional feature: define BOOTH_SEQ_ABORT_EN to add an abort input that cancels an in-flight request.
module booth_seq_ctrl (
    input logic             clk,
    input logic             reset,
    booth_seq_ctrl_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    typedef enum logic [1:0] {IDLE, ITER, ADD} state_t;

    state_t                   state;
    logic        [1:0]        k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] a_q;
    logic        [ACC_W-1:0]  b_q;
    logic                     cin_q;
    logic                     done_q;
    logic        [ACC_W-1:0]  sum_q;
    logic                     carry_q;
    logic signed [ACC_W-1:0]  pp;
    logic                     abort_hit;

    // Digit k looks at {a[2k+1], a[2k], a[2k-1]}; the padded LSB supplies a[-1] = 0.
    function automatic logic signed [ACC_W-1:0] booth_pp(input logic signed [DATA_W-1:0] a,
                                                         input logic [1:0] digit);
        logic        [DATA_W:0]  a_pad;
        logic        [2:0]       sel;
        logic signed [ACC_W-1:0] a_ext;
        logic signed [ACC_W-1:0] mag;
        a_pad = {a, 1'b0};
        sel   = a_pad[{digit, 1'b0} +: 3];
        a_ext = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
        case (sel)
            3'b001, 3'b010: mag = a_ext;
            3'b011:         mag = a_ext <<< 1;
            3'b100:         mag = -(a_ext <<< 1);
            3'b101, 3'b110: mag = -a_ext;
            default:        mag = '0;
        endcase
        return mag <<< {digit, 1'b0};
    endfunction

    function automatic logic [ACC_W:0] final_add(input logic [ACC_W-1:0] acc_v,
                                                 input logic [ACC_W-1:0] b_v,
                                                 input logic             cin);
        return {1'b0, acc_v} + {1'b0, b_v} + {{ACC_W{1'b0}}, cin};
    endfunction

    assign pp = booth_pp(a_q, k);

`ifdef BOOTH_SEQ_ABORT_EN
    assign abort_hit = bus.abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            k       <= '0;
            acc     <= '0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= ITER;
                        k     <= '0;
                        acc   <= '0;
                    end
                end
                ITER: begin
                    if (abort_hit) begin
                        state <= IDLE;
                        k     <= '0;
                    end else begin
                        acc <= acc + pp;
                        k   <= k + 2'd1;
                        if (k == 2'd3) state <= ADD;
                    end
                end
                ADD: begin
                    // Abort outranks completion: results stay untouched and no done pulse.
                    if (!abort_hit) begin
                        {carry_q, sum_q} <= final_add(acc, b_q, cin_q);
                        done_q           <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand capture on accept only; later input changes cannot disturb a running request.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            cin_q <= bus.in_car;
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed literal cases plus randomized traffic against a cycle-count model.
module tb_booth_seq_ctrl;
    logic clk;
    logic reset;
    booth_seq_ctrl_if bus();

    booth_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: cycles elapsed since accept, result from plain integer arithmetic.
    int          m_phase   = 0;
    int          m_res     = 0;
    logic [15:0] exp_sum   = '0;
    logic        exp_carry = 1'b0;
    logic        exp_done  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        int  ia;
        bit  ab;
        if (!reset) begin
            m_phase   = 0;
            exp_done  = 1'b0;
            exp_sum   = '0;
            exp_carry = 1'b0;
        end else begin
            ab = 1'b0;
`ifdef BOOTH_SEQ_ABORT_EN
            ab = bus.abort;
`endif
            exp_done = 1'b0;
            if (m_phase != 0 && ab) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (bus.start) begin
                    ia      = int'(bus.A);
                    m_res   = ia * ia + int'(bus.B) + int'(bus.in_car);
                    m_phase = 1;
                end
            end else if (m_phase < 5) begin
                m_phase++;
            end else begin
                exp_sum   = m_res[15:0];
                exp_carry = m_res[16];
                exp_done  = 1'b1;
                m_phase   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  32'(bus.busy),  32'(m_phase != 0));
            check("done",  32'(bus.done),  32'(exp_done));
            check("sum",   32'(bus.sum),   32'(exp_sum));
            check("carry", 32'(bus.carry), 32'(exp_carry));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            errors++;
            $display("FAIL idle_timeout busy stuck at %0t", $time);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done) break;
        end
        if (!bus.done) begin
            errors++;
            $display("FAIL done_timeout no done within %0d cycles", cyc);
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] x_sum, input logic x_carry);
        int cyc;
        wait_idle();
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.in_car = cin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(cyc);
        check({name, "_latency"}, 32'(cyc), 32'd5);
        check({name, "_sum"},     32'(bus.sum), 32'(x_sum));
        check({name, "_carry"},   32'(bus.carry), 32'(x_carry));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int seen;
        reset = 1'b0;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.in_car = 1'b0;
`ifdef BOOTH_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        #1;
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_sum",   32'(bus.sum),   32'd0);
        check("rst_carry", 32'(bus.carry), 32'd0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("a5",   8'd5,   16'hFFFF, 1'b0, 16'h0018, 1'b1);
        run_op("a80",  8'h80,  16'hFFFF, 1'b0, 16'h3FFF, 1'b1);
        run_op("a7f",  8'h7F,  16'hFFFF, 1'b0, 16'h3F00, 1'b1);
        run_op("a0",   8'h00,  16'hFFFF, 1'b0, 16'hFFFF, 1'b0);
        run_op("afd",  8'hFD,  16'h0010, 1'b1, 16'h001A, 1'b0);

        // Start held high: second request only accepted once the first has finished.
        wait_idle();
        bus.start = 1'b1; bus.A = 8'd2; bus.B = 16'hFFFF; bus.in_car = 1'b0;
        @(posedge clk); #1;
        bus.A = 8'd3;
        wait_done(t);
        check("b2b_first_sum", 32'(bus.sum), 32'h0003);
        wait_done(t);
        bus.start = 1'b0;
        check("b2b_spacing",    32'(t), 32'd6);
        check("b2b_second_sum", 32'(bus.sum), 32'h0008);

        // Asynchronous reset two cycles into the iteration.
        wait_idle();
        bus.start = 1'b1; bus.A = 8'd5; bus.B = 16'hFFFF; bus.in_car = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("amid_busy",  32'(bus.busy),  32'd0);
        check("amid_done",  32'(bus.done),  32'd0);
        check("amid_sum",   32'(bus.sum),   32'd0);
        check("amid_carry", 32'(bus.carry), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 8'hFD, 16'h0010, 1'b1, 16'h001A, 1'b0);

`ifdef BOOTH_SEQ_ABORT_EN
        run_op("pre_abort", 8'd5, 16'hFFFF, 1'b0, 16'h0018, 1'b1);
        bus.start = 1'b1; bus.A = 8'd7; bus.B = 16'h1234; bus.in_car = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_sum",     32'(bus.sum),   32'h0018);
        check("abort_carry",   32'(bus.carry), 32'd1);
        run_op("post_abort", 8'd3, 16'hFFFF, 1'b0, 16'h0008, 1'b1);
`endif

        // Random traffic; the per-cycle compare process judges it against the model.
        for (int i = 0; i < 400; i++) begin
            bus.start  = ($urandom_range(2) == 0);
            bus.A      = 8'($urandom);
            bus.B      = 16'($urandom);
            bus.in_car = 1'($urandom);
`ifdef BOOTH_SEQ_ABORT_EN
            bus.abort  = ($urandom_range(15) == 0);
`endif
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
`ifdef BOOTH_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (10) @(posedge clk);
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Multi-cycle sequencer for the signed A²+B calculator. It computes A·A + B + in_car on an 8-bit signed operand A using a single radix-4 Booth partial-product step per cycle instead of a fully parallel Booth array. It registers the 16-bit sum and carry-out, and exposes a start/busy/done handshake so a host FSM can issue requests back to back. The A²−1 use case is B = 16'hFFFF, in_car = 0.

## Interface
Parameters:
- none (widths fixed: A 8-bit signed, B/sum 16-bit)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  request pulse/level; sampled only in IDLE
- A  input  8  signed multiplicand/multiplier, captured on accept
- B  input  16  addend, captured on accept
- in_car  input  1  carry-in, captured on accept
- busy  output  1  high while a computation is in flight
- done  output  1  one-cycle pulse when sum/carry are updated
- sum  output  16  registered result low 16 bits
- carry  output  1  registered carry-out of final add
- abort  input  1  only present with BOOTH_SEQ_ABORT_EN

## Operation
- States: IDLE, ITER, ADD.
- IDLE:
  - If start = 1 at a clock edge, capture A, B and in_car, clear the accumulator, set digit counter k = 0, and go to ITER.
  - Otherwise stay in IDLE.
- ITER, one Booth digit per cycle, k = 0..3:
  - Digit select is {A[2k+1], A[2k], A[2k−1]}, with A[−1] = 0.
  - Partial product is one of {0, +A, +2A, −A, −2A}, sign-extended to 16 bits and shifted left by 2k.
  - acc ← acc + pp, mod 2^16.
  - After k = 3, go to ADD.
- ADD:
  - {carry, sum} ← acc + B + in_car, as a 17-bit unsigned add.
  - done = 1 for one cycle. Go to IDLE.
- Arithmetic: A² for A ∈ [−128, 127] is at most 16384 and always fits in 16 bits, so the accumulator never overflows.
- sum and carry hold their last value until the next ADD. Only ADD updates them.
- start while busy = 1 is ignored; the request is dropped, not queued.
- Captured operands are immune to A/B/in_car changes after accept.
- Reset (reset = 0, any state, including mid-ITER) forces the following immediately and asynchronously:
  - state = IDLE, k = 0, acc = 0
  - busy = 0, done = 0, sum = 0, carry = 0

## Timing
- Accept edge N, with start = 1 in IDLE: busy = 1 from after edge N.
- Edges N+1 … N+4: digits 0..3 processed.
- Edge N+5: ADD result registered, done = 1, busy = 0. Latency is 5 cycles from accept to done.
- Back-to-back: start = 1 during the done cycle is accepted at edge N+6 (IDLE). Maximum throughput is one result per 6 cycles.
- busy is combinationally equivalent to (state != IDLE) and is registered via the state.

## Configuration
- BOOTH_SEQ_ABORT_EN defined:
  - Adds the abort input.
  - abort = 1 at an edge in ITER or ADD returns the block to IDLE with busy = 0.
  - No done pulse is generated, and sum/carry keep their previous values.
  - abort has priority over completion in ADD.
  - abort in IDLE has no effect, and a start at the same edge is still accepted.
- Not defined: no abort port; every accepted request runs to completion.

## Test plan
- Case A = 8'd5, B = 16'hFFFF, in_car = 0: start → done at 5 cycles after accept, sum = 16'h0018, carry = 1.
- Case A = 8'h80 (−128), B = 16'hFFFF, in_car = 0: sum = 16'h3FFF, carry = 1. Case A = 8'h7F: sum = 16'h3F00, carry = 1. Case A = 0: sum = 16'hFFFF, carry = 0.
- Case A = 8'hFD (−3), B = 16'h0010, in_car = 1: sum = 16'h001A, carry = 0.
- Start held high continuously with A = 2 then A = 3: results 16'h0003 and 16'h0008 (B = 16'hFFFF) on done pulses 6 cycles apart. Starts during busy are ignored, and A changes while busy do not affect the result.
- Drive reset = 0 mid-ITER (2 cycles after accept): busy, done, sum and carry go to 0 immediately without waiting for clk. After release, a new start yields the correct result.
- With BOOTH_SEQ_ABORT_EN, abort at cycle 3 after accept:
  - busy drops and no done is issued.
  - sum/carry retain the prior values.
  - The next start completes normally.
